// File: rtl/axi_lite_regfile_if.sv
// AXI-Lite channel bundle shared by the register file and its requester.
`timescale 1ns/1ps
interface axi_lite_channel #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      aw_valid;
    logic                      aw_ready;
    logic [ADDR_WIDTH-1:0]     aw_addr;
    logic [2:0]                aw_prot;
    logic                      w_valid;
    logic                      w_ready;
    logic [DATA_WIDTH-1:0]     w_data;
    logic [DATA_WIDTH/8-1:0]   w_strb;
    logic                      b_valid;
    logic                      b_ready;
    logic [1:0]                b_resp;
    logic                      ar_valid;
    logic                      ar_ready;
    logic [ADDR_WIDTH-1:0]     ar_addr;
    logic [2:0]                ar_prot;
    logic                      r_valid;
    logic                      r_ready;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [1:0]                r_resp;

    modport master (
        output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
               ar_valid, ar_addr, ar_prot, r_ready,
        input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );

    modport slave (
        input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
               ar_valid, ar_addr, ar_prot, r_ready,
        output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );
endinterface

// File: rtl/axi_lite_regfile.sv
// AXI-Lite register file: REG_COUNT byte-strobed registers with independent
// AW/W holding slots, one outstanding B and one outstanding R response.
`timescale 1ns/1ps
module axi_lite_regfile #(
    parameter int          REG_COUNT   = 16,
    parameter logic [63:0] RESET_VALUE = '0,
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    axi_lite_channel.slave                  master,
    output logic [REG_COUNT*DATA_WIDTH-1:0] regs_o,
    output logic [REG_COUNT-1:0]            wr_pulse_o
);
    localparam int         STRB_W   = DATA_WIDTH / 8;
    localparam int         OFFS_W   = $clog2(STRB_W);
    localparam int         IDX_BITS = ADDR_WIDTH - OFFS_W;
    localparam int         SEL_W    = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam logic [1:0] OKAY     = 2'b00;
    localparam logic [1:0] SLVERR   = 2'b10;

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
        $fatal(1, "axi_lite_regfile: DATA_WIDTH must be 32 or 64");
    end
    if (REG_COUNT < 1) begin : g_bad_reg_count
        $fatal(1, "axi_lite_regfile: REG_COUNT must be at least 1");
    end
    if (IDX_BITS < SEL_W ||
        (IDX_BITS < 62 && longint'(REG_COUNT) > (longint'(1) << IDX_BITS))) begin : g_bad_addr_space
        $fatal(1, "axi_lite_regfile: REG_COUNT words do not fit the address space");
    end

    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;
    logic                  b_valid_q;
    logic [1:0]            b_resp_q;
    logic                  r_valid_q;
    logic [1:0]            r_resp_q;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic [REG_COUNT-1:0]  wr_pulse_q;
    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] aw_word;
    logic [ADDR_WIDTH-1:0] ar_word;
    logic                  aw_in_range;
    logic                  ar_in_range;
    logic [SEL_W-1:0]      aw_sel;
    logic [SEL_W-1:0]      ar_sel;
    logic                  unused_prot;

    assign unused_prot = ^{master.aw_prot, master.ar_prot};

    assign aw_hs  = master.aw_valid && !aw_held;
    assign w_hs   = master.w_valid && !w_held;
    assign ar_hs  = master.ar_valid && !r_valid_q;
    // A pending response blocks the commit, so the slots (and readiness) stay full.
    assign commit = aw_held && w_held && !b_valid_q;

    assign aw_word     = aw_addr_q >> OFFS_W;
    assign ar_word     = master.ar_addr >> OFFS_W;
    assign aw_in_range = aw_word < ADDR_WIDTH'(REG_COUNT);
    assign ar_in_range = ar_word < ADDR_WIDTH'(REG_COUNT);
    assign aw_sel      = aw_word[SEL_W-1:0];
    assign ar_sel      = ar_word[SEL_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= OKAY;
            r_valid_q  <= 1'b0;
            r_resp_q   <= OKAY;
            r_data_q   <= '0;
            wr_pulse_q <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= RESET_VALUE[DATA_WIDTH-1:0];
            end
        end else begin
            wr_pulse_q <= '0;

            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= master.aw_addr;
            end else if (commit) begin
                aw_held <= 1'b0;
            end

            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= master.w_data;
                w_strb_q <= master.w_strb;
            end else if (commit) begin
                w_held <= 1'b0;
            end

            if (commit) begin
                b_valid_q <= 1'b1;
                b_resp_q  <= aw_in_range ? OKAY : SLVERR;
                if (aw_in_range) begin
                    wr_pulse_q[aw_sel] <= 1'b1;
                    for (int k = 0; k < STRB_W; k++) begin
                        if (w_strb_q[k]) begin
                            regs_q[aw_sel][k*8 +: 8] <= w_data_q[k*8 +: 8];
                        end
                    end
                end
            end else if (b_valid_q && master.b_ready) begin
                b_valid_q <= 1'b0;
            end

            // regs_q here is the pre-commit value, giving read-before-write ordering.
            if (ar_hs) begin
                r_valid_q <= 1'b1;
                r_resp_q  <= ar_in_range ? OKAY : SLVERR;
                r_data_q  <= ar_in_range ? regs_q[ar_sel] : '0;
            end else if (r_valid_q && master.r_ready) begin
                r_valid_q <= 1'b0;
            end
        end
    end

    assign master.aw_ready = !aw_held;
    assign master.w_ready  = !w_held;
    assign master.b_valid  = b_valid_q;
    assign master.b_resp   = b_resp_q;
    assign master.ar_ready = !r_valid_q;
    assign master.r_valid  = r_valid_q;
    assign master.r_data   = r_data_q;
    assign master.r_resp   = r_resp_q;

    for (genvar i = 0; i < REG_COUNT; i++) begin : g_regs_out
        assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end

    assign wr_pulse_o = wr_pulse_q;
endmodule

// File: tb/tb_axi_lite_regfile.sv
// Bench for axi_lite_regfile: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_axi_lite_regfile;
    localparam int RC = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [511:0]  regs_o;
    logic [RC-1:0] wr_pulse_o;

    axi_lite_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_lite_regfile #(.REG_COUNT(RC)) dut (
        .clk       (clk),
        .rst       (rst),
        .master    (bus),
        .regs_o    (regs_o),
        .wr_pulse_o(wr_pulse_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [RC];
    logic [31:0] aw_slot [$];
    logic [35:0] w_slot [$];
    bit          m_bvalid;
    logic [1:0]  m_bresp;
    int          m_pulse;
    bit          m_rvalid;
    logic [1:0]  m_rresp;
    logic [31:0] m_rdata;
    bit          m_live = 0;

    bit          mc_commit;
    bit          mc_aw_acc;
    bit          mc_w_acc;
    logic [31:0] mc_addr;
    logic [35:0] mc_w;
    int          mc_idx;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RC; i++) m_regs[i] = 32'h0;
            aw_slot.delete();
            w_slot.delete();
            m_bvalid = 0;
            m_bresp  = 2'b00;
            m_pulse  = -1;
            m_rvalid = 0;
            m_rresp  = 2'b00;
            m_rdata  = 32'h0;
            m_live   = 1;
        end else if (m_live) begin
            mc_aw_acc = bus.aw_valid && (aw_slot.size() == 0);
            mc_w_acc  = bus.w_valid && (w_slot.size() == 0);
            mc_commit = (aw_slot.size() != 0) && (w_slot.size() != 0) && !m_bvalid;

            if (m_rvalid) begin
                if (bus.r_ready) m_rvalid = 0;
            end else if (bus.ar_valid) begin
                m_rvalid = 1;
                if ((bus.ar_addr / 4) < RC) begin
                    m_rresp = 2'b00;
                    m_rdata = m_regs[bus.ar_addr / 4];
                end else begin
                    m_rresp = 2'b10;
                    m_rdata = 32'h0;
                end
            end

            m_pulse = -1;
            if (m_bvalid) begin
                if (bus.b_ready) m_bvalid = 0;
            end else if (mc_commit) begin
                mc_addr  = aw_slot.pop_front();
                mc_w     = w_slot.pop_front();
                m_bvalid = 1;
                if ((mc_addr / 4) < RC) begin
                    mc_idx  = int'(mc_addr / 4);
                    m_bresp = 2'b00;
                    m_pulse = mc_idx;
                    for (int k = 0; k < 4; k++)
                        if (mc_w[32+k]) m_regs[mc_idx][k*8 +: 8] = mc_w[k*8 +: 8];
                end else begin
                    m_bresp = 2'b10;
                end
            end

            if (mc_aw_acc) aw_slot.push_back(bus.aw_addr);
            if (mc_w_acc)  w_slot.push_back({bus.w_strb, bus.w_data});
        end
    end

    logic [511:0]  exp_regs;
    logic [RC-1:0] exp_pulse;

    always @(negedge clk) begin
        if (m_live) begin
            for (int i = 0; i < RC; i++) exp_regs[i*32 +: 32] = m_regs[i];
            exp_pulse = '0;
            if (m_pulse >= 0) exp_pulse[m_pulse] = 1'b1;
            check("m_aw_ready", bus.aw_ready, aw_slot.size() == 0);
            check("m_w_ready",  bus.w_ready,  w_slot.size() == 0);
            check("m_ar_ready", bus.ar_ready, !m_rvalid);
            check("m_b_valid",  bus.b_valid,  m_bvalid);
            if (m_bvalid) check("m_b_resp", bus.b_resp, m_bresp);
            check("m_r_valid",  bus.r_valid,  m_rvalid);
            if (m_rvalid) begin
                check("m_r_resp", bus.r_resp, m_rresp);
                check("m_r_data", bus.r_data, m_rdata);
            end
            check("m_wr_pulse", wr_pulse_o, exp_pulse);
            check("m_regs",     regs_o,     exp_regs);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.aw_valid = 0; bus.aw_addr = '0; bus.aw_prot = '0;
        bus.w_valid  = 0; bus.w_data  = '0; bus.w_strb  = '0;
        bus.ar_valid = 0; bus.ar_addr = '0; bus.ar_prot = '0;
        bus.b_ready  = 1; bus.r_ready = 1;
    endtask

    task automatic put_aw(input logic [31:0] a);
        bus.aw_valid = 1; bus.aw_addr = a;
    endtask

    task automatic put_w(input logic [31:0] d, input logic [3:0] s);
        bus.w_valid = 1; bus.w_data = d; bus.w_strb = s;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(0, 7) == 0) a = $urandom;
        else a = ($urandom_range(0, RC + 3) << 2) | $urandom_range(0, 3);
        return a;
    endfunction

    logic [511:0] lit;

    initial begin
        idle_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        check("rst_aw_ready", bus.aw_ready, 1'b1);
        check("rst_w_ready",  bus.w_ready,  1'b1);
        check("rst_ar_ready", bus.ar_ready, 1'b1);
        check("rst_b_valid",  bus.b_valid,  1'b0);
        check("rst_r_valid",  bus.r_valid,  1'b0);
        check("rst_regs",     regs_o,       512'h0);

        // Simultaneous AW/W
        put_aw(32'h4); put_w(32'hDEADBEEF, 4'hF);
        tick();
        bus.aw_valid = 0; bus.w_valid = 0;
        check("s1_b_early", bus.b_valid, 1'b0);
        tick();
        check("s1_b_valid", bus.b_valid, 1'b1);
        check("s1_b_resp",  bus.b_resp,  2'b00);
        check("s1_pulse",   wr_pulse_o,  16'h0002);
        tick();
        check("s1_pulse_off", wr_pulse_o, 16'h0000);
        check("s1_word1",     regs_o[63:32], 32'hDEADBEEF);

        // W three cycles ahead of AW, partial strobe
        put_w(32'h1234ABCD, 4'h3);
        tick();
        bus.w_valid = 0;
        check("s2_w_ready_a", bus.w_ready, 1'b0);
        tick();
        check("s2_w_ready_b", bus.w_ready, 1'b0);
        tick();
        check("s2_w_ready_c", bus.w_ready, 1'b0);
        put_aw(32'h0);
        tick();
        bus.aw_valid = 0;
        check("s2_w_ready_d", bus.w_ready, 1'b0);
        tick();
        check("s2_b_valid", bus.b_valid, 1'b1);
        check("s2_w_ready", bus.w_ready, 1'b1);
        check("s2_word0",   regs_o[31:0], 32'h0000ABCD);
        tick();

        // Out-of-range read and write
        bus.ar_valid = 1; bus.ar_addr = RC * 4; bus.r_ready = 0;
        tick();
        bus.ar_valid = 0;
        check("s3_r_valid", bus.r_valid, 1'b1);
        check("s3_r_resp",  bus.r_resp,  2'b10);
        check("s3_r_data",  bus.r_data,  32'h0);
        bus.r_ready = 1;
        tick();
        check("s3_r_clear", bus.r_valid, 1'b0);
        put_aw(RC * 4); put_w(32'hFFFFFFFF, 4'hF);
        tick();
        bus.aw_valid = 0; bus.w_valid = 0;
        tick();
        lit = '0; lit[31:0] = 32'h0000ABCD; lit[63:32] = 32'hDEADBEEF;
        check("s3_b_resp", bus.b_resp, 2'b10);
        check("s3_pulse",  wr_pulse_o, 16'h0000);
        check("s3_regs",   regs_o,     lit);
        tick();

        // Stalled B with a second pair queued
        bus.b_ready = 0;
        put_aw(32'h8); put_w(32'hA5A5A5A5, 4'hF);
        tick();
        bus.aw_valid = 0; bus.w_valid = 0;
        tick();
        put_aw(32'hC); put_w(32'h0BADF00D, 4'hF);
        tick();
        bus.aw_valid = 0; bus.w_valid = 0;
        for (int i = 0; i < 4; i++) begin
            check("s4_b_hold",  bus.b_valid, 1'b1);
            check("s4_b_resp",  bus.b_resp,  2'b00);
            check("s4_aw_full", bus.aw_ready, 1'b0);
            check("s4_w_full",  bus.w_ready,  1'b0);
            check("s4_word3",   regs_o[127:96], 32'h0);
            tick();
        end
        bus.b_ready = 1;
        tick();
        check("s4_b_drop", bus.b_valid, 1'b0);
        tick();
        check("s4_b2_valid", bus.b_valid, 1'b1);
        check("s4_b2_pulse", wr_pulse_o,  16'h0008);
        check("s4_b2_word3", regs_o[127:96], 32'h0BADF00D);
        tick();

        // Read colliding with a commit to the same register
        put_aw(32'h8); put_w(32'h11, 4'hF);
        tick();
        bus.aw_valid = 0; bus.w_valid = 0;
        tick(); tick();
        put_aw(32'h8); put_w(32'h55, 4'hF);
        tick();
        bus.aw_valid = 0; bus.w_valid = 0;
        bus.ar_valid = 1; bus.ar_addr = 32'h8; bus.r_ready = 0;
        tick();
        bus.ar_valid = 0;
        check("s5_r_old",  bus.r_data, 32'h11);
        check("s5_word2",  regs_o[95:64], 32'h55);
        bus.r_ready = 1;
        tick();
        bus.ar_valid = 1; bus.ar_addr = 32'h8;
        tick();
        bus.ar_valid = 0;
        check("s5_r_new", bus.r_data, 32'h55);
        tick();

        // Reset with transactions in flight
        put_aw(32'h4);
        bus.ar_valid = 1; bus.ar_addr = 32'h0; bus.r_ready = 0;
        tick();
        bus.aw_valid = 0; bus.ar_valid = 0;
        check("s6_aw_held", bus.aw_ready, 1'b0);
        check("s6_r_valid", bus.r_valid,  1'b1);
        rst = 1;
        tick();
        rst = 0;
        bus.r_ready = 1;
        check("s6_aw_ready", bus.aw_ready, 1'b1);
        check("s6_w_ready",  bus.w_ready,  1'b1);
        check("s6_ar_ready", bus.ar_ready, 1'b1);
        check("s6_b_valid",  bus.b_valid,  1'b0);
        check("s6_r_valid0", bus.r_valid,  1'b0);
        check("s6_regs",     regs_o,       512'h0);
        check("s6_pulse",    wr_pulse_o,   16'h0);
        put_w(32'h77, 4'hF);
        tick();
        bus.w_valid = 0;
        tick(); tick();
        check("s6_no_b", bus.b_valid, 1'b0);
        put_aw(32'h14);
        tick();
        bus.aw_valid = 0;
        tick();
        check("s6_fresh_b", bus.b_valid, 1'b1);
        tick();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            bus.aw_valid = ($urandom_range(0, 2) == 0);
            bus.aw_addr  = rand_addr();
            bus.aw_prot  = 3'($urandom_range(0, 7));
            bus.w_valid  = ($urandom_range(0, 2) == 0);
            bus.w_data   = $urandom;
            bus.w_strb   = 4'($urandom_range(0, 15));
            bus.ar_valid = ($urandom_range(0, 2) == 0);
            bus.ar_addr  = rand_addr();
            bus.ar_prot  = 3'($urandom_range(0, 7));
            bus.b_ready  = ($urandom_range(0, 3) != 0);
            bus.r_ready  = ($urandom_range(0, 3) != 0);
            rst          = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst = 0;
        idle_inputs();
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
